alu_8bit: RTL and testbench
===========================

// Module: alu_8bit
// PURPOSE
//   8-bit registered ALU with 16 operations selected by a 4-bit opcode.
//   Combinational datapath computes result and carry/flag from operand_a, operand_b and operation.
//   The value is captured into output registers on every rising clock edge.
//   Standalone arithmetic block, driven directly by a control unit or test stimulus.
// PARAMETERS
//   WIDTH  8  operand/result width; all behaviour below is specified for 8.
// PORTS
//   clk        in   1  system clock, rising edge; the block's only clock
//   rst_n      in   1  asynchronous, active-low reset
//   operand_a  in   8  first operand (unsigned)
//   operand_b  in   8  second operand (unsigned)
//   operation  in   4  opcode, see BEHAVIOUR
//   result     out  8  registered result
//   carry_out  out  1  registered carry/borrow/error flag
// BEHAVIOUR
//   - rst_n=0: result=8'h00, carry_out=0 immediately, independent of clk; held while low.
//   - Reset asserted mid-operation discards any in-flight value. The first capture is at the first rising clk after rst_n deasserts.
//   - Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Inputs are sampled every cycle; there is no handshake.
//   - Opcodes (a=operand_a, b=operand_b; carry_out=0 unless stated):
//     0 ADD   a+b; carry = bit 8 of the 9-bit sum
//     1 SUB   a-b mod 256; carry = borrow (1 iff a<b)
//     2 MUL   low byte of a*b; carry = 1 iff the high byte is nonzero
//     3 DIV   a/b (unsigned quotient); b==0 -> result 8'hFF, carry=1
//     4 SHL   a<<1; carry = a[7]
//     5 SHR   a>>1 (logical); carry = a[0]
//     6 ROL   {a[6:0],a[7]}; carry = a[7]
//     7 ROR   {a[0],a[7:1]}; carry = a[0]
//     8 AND   9 OR   A XOR   B NOR   C NAND   D XNOR  (bitwise)
//     E GT    8'h01 if a>b (unsigned), else 8'h00
//     F EQ    8'h01 if a==b, else 8'h00
//   - All arithmetic is unsigned. Results wrap modulo 256.
//   - No X propagation: every opcode decodes; the case statement has a default that yields 8'h00.
// CONFIGURATION
//   ALU_STATUS_FLAGS_EN defined: adds registered outputs zero_flag (result==0), neg_flag (result[7]) and ovf_flag.
//     ovf_flag is signed overflow for ADD/SUB and 0 for all other opcodes.
//     The flags share the reset (all 0) and the 1-cycle latency of result.
//   Not defined: these ports and their logic do not exist; all other behaviour is identical.
// STRUCTURE
//   Package alu_pkg: opcode localparams/enum (OP_ADD..OP_EQ), ALU_WIDTH=8.
//   Sub-module alu_8bit_core: purely combinational opcode decode and datapath.
//   Top level: alu_8bit_core plus the output register stage with asynchronous reset.
// TESTING
//   - rst_n=0 with random inputs and a running clock -> result=00, carry_out=0; release -> the next edge loads the ALU value.
//   - ADD 33+CC -> FF, c=0; ADD FF+01 -> 00, c=1; SUB 05-07 -> FE, c=1.
//   - MUL 10*10 -> 00, c=1; MUL 03*05 -> 0F, c=0; DIV 64/07 -> 0E, c=0; DIV 10/00 -> FF, c=1.
//   - SHL 81 -> 02, c=1; SHR 81 -> 40, c=1; ROL 81 -> 03, c=1; ROR 01 -> 80, c=1.
//   - AND/OR/XOR/NOR/NAND/XNOR of 33,CC -> 00/FF/FF/00/FF/00, c=0; GT 05,03 -> 01; EQ 5A,5A -> 01.
//   - 1000 cycles of random a/b/op against a reference model delayed 1 cycle -> exact match.
//   - Reset pulse mid-stream -> outputs clear asynchronously, then resume correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: datapath width and the opcode encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_OP_W  = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_8bit_core.sv
// Combinational opcode decode and datapath of the ALU.
// Optional signed-overflow output exists only when ALU_STATUS_FLAGS_EN is defined.
module alu_8bit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [ALU_OP_W-1:0] i_op,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_carry
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic                o_ovf
`endif
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic               w_b_zero;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    // Bit WIDTH of the extended difference is the borrow (set iff a < b).
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod   = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_b_zero = (i_b == '0);
    assign w_quot   = w_b_zero ? '1 : (i_a / i_b);

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_carry  = w_diff[WIDTH];
            end
            OP_MUL: begin
                o_result = w_prod[WIDTH-1:0];
                o_carry  = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                o_result = w_quot;
                o_carry  = w_b_zero;
            end
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_carry  = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            OP_ROL: begin
                o_result = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
                o_carry  = i_a[WIDTH-1];
            end
            OP_ROR: begin
                o_result = {i_a[0], i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_NAND: o_result = ~(i_a & i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_GT:   o_result = {{(WIDTH-1){1'b0}}, (i_a > i_b)};
            OP_EQ:   o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            default: o_result = '0;
        endcase
    end

`ifdef ALU_STATUS_FLAGS_EN
    // Two's-complement overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        o_ovf = 1'b0;
        if (i_op == OP_ADD)
            o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        else if (i_op == OP_SUB)
            o_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    end
`endif

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: combinational core followed by one output register stage.
// Define ALU_STATUS_FLAGS_EN to add registered zero_flag, neg_flag and ovf_flag outputs.
module alu_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    input  logic [ALU_OP_W-1:0] operation,
    output logic [WIDTH-1:0]    result,
    output logic                carry_out
`ifdef ALU_STATUS_FLAGS_EN
    ,
    output logic                zero_flag,
    output logic                neg_flag,
    output logic                ovf_flag
`endif
);

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;

`ifdef ALU_STATUS_FLAGS_EN
    logic w_ovf;
    logic r_zero;
    logic r_neg;
    logic r_ovf;
`endif

    alu_8bit_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .i_a      (operand_a),
        .i_b      (operand_b),
        .i_op     (operation),
        .o_result (w_result),
        .o_carry  (w_carry)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .o_ovf    (w_ovf)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_result;
            r_carry  <= w_carry;
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;

`ifdef ALU_STATUS_FLAGS_EN
    // Flags describe the value being captured, so they share its one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_zero <= (w_result == '0);
            r_neg  <= w_result[WIDTH-1];
            r_ovf  <= w_ovf;
        end
    end

    assign zero_flag = r_zero;
    assign neg_flag  = r_neg;
    assign ovf_flag  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vector table, random run against an arithmetic model, reset sequences.
// Checks the status flags too when ALU_STATUS_FLAGS_EN is defined.
module tb_alu_8bit;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [3:0] operation;
    logic [7:0] result;
    logic       carry_out;
`ifdef ALU_STATUS_FLAGS_EN
    logic       zero_flag;
    logic       neg_flag;
    logic       ovf_flag;
`endif

    int checks = 0;
    int errors = 0;

    alu_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operation (operation),
        .result    (result),
        .carry_out (carry_out)
`ifdef ALU_STATUS_FLAGS_EN
        ,
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag),
        .ovf_flag  (ovf_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
    } vec_t;

    vec_t vecs[22];

    // Reference model from plain integer arithmetic on the opcode rules.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic v);
        int ia = int'(a);
        int ib = int'(b);
        int sa = (ia > 127) ? ia - 256 : ia;
        int sb = (ib > 127) ? ib - 256 : ib;
        int t;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin t = ia + ib; r = 8'(t % 256); c = (t > 255);
                        v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            4'h1: begin t = ia - ib + 256; r = 8'(t % 256); c = (ia < ib);
                        v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            4'h2: begin t = ia * ib; r = 8'(t % 256); c = (t > 255); end
            4'h3: begin if (ib == 0) begin r = 8'hFF; c = 1'b1; end
                        else r = 8'(ia / ib); end
            4'h4: begin r = 8'((ia * 2) % 256); c = (ia >= 128); end
            4'h5: begin r = 8'(ia / 2); c = (ia % 2 == 1); end
            4'h6: begin r = 8'((ia * 2) % 256 + ia / 128); c = (ia >= 128); end
            4'h7: begin r = 8'(ia / 2 + (ia % 2) * 128); c = (ia % 2 == 1); end
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD: r = ~(a ^ b);
            4'hE: r = (ia > ib) ? 8'h01 : 8'h00;
            default: r = (ia == ib) ? 8'h01 : 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] er, input logic ec,
                         input logic ez, input logic en, input logic ev);
        checks++;
        if (result !== er || carry_out !== ec) begin
            errors++;
            $display("FAIL %s: got result=%h carry=%b, expected result=%h carry=%b", name, result, carry_out, er, ec);
        end
`ifdef ALU_STATUS_FLAGS_EN
        checks++;
        if (zero_flag !== ez || neg_flag !== en || ovf_flag !== ev) begin
            errors++;
            $display("FAIL %s_flags: got z/n/v=%b%b%b, expected z/n/v=%b%b%b", name,
                     zero_flag, neg_flag, ovf_flag, ez, en, ev);
        end
`else
        if (ez === 1'bx && en === 1'bx && ev === 1'bx) $display("note: unknown flag expectation");
`endif
    endtask

    task automatic check_val(input string name, input logic [7:0] er, input logic ec, input logic ev);
        check(name, er, ec, (er == 8'h00), er[7], ev);
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        operation = op;
        operand_a = a;
        operand_b = b;
    endtask

    initial begin
        logic [7:0] er;
        logic       ec;
        logic       ev;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rop;

        vecs[0]  = '{"add_33_cc",  OP_ADD,  8'h33, 8'hCC, 8'hFF, 1'b0};
        vecs[1]  = '{"add_ff_01",  OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2]  = '{"sub_05_07",  OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b1};
        vecs[3]  = '{"mul_10_10",  OP_MUL,  8'h10, 8'h10, 8'h00, 1'b1};
        vecs[4]  = '{"mul_03_05",  OP_MUL,  8'h03, 8'h05, 8'h0F, 1'b0};
        vecs[5]  = '{"div_64_07",  OP_DIV,  8'h64, 8'h07, 8'h0E, 1'b0};
        vecs[6]  = '{"div_10_00",  OP_DIV,  8'h10, 8'h00, 8'hFF, 1'b1};
        vecs[7]  = '{"shl_81",     OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1};
        vecs[8]  = '{"shr_81",     OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1};
        vecs[9]  = '{"rol_81",     OP_ROL,  8'h81, 8'h00, 8'h03, 1'b1};
        vecs[10] = '{"ror_01",     OP_ROR,  8'h01, 8'h00, 8'h80, 1'b1};
        vecs[11] = '{"and_33_cc",  OP_AND,  8'h33, 8'hCC, 8'h00, 1'b0};
        vecs[12] = '{"or_33_cc",   OP_OR,   8'h33, 8'hCC, 8'hFF, 1'b0};
        vecs[13] = '{"xor_33_cc",  OP_XOR,  8'h33, 8'hCC, 8'hFF, 1'b0};
        vecs[14] = '{"nor_33_cc",  OP_NOR,  8'h33, 8'hCC, 8'h00, 1'b0};
        vecs[15] = '{"nand_33_cc", OP_NAND, 8'h33, 8'hCC, 8'hFF, 1'b0};
        vecs[16] = '{"xnor_33_cc", OP_XNOR, 8'h33, 8'hCC, 8'h00, 1'b0};
        vecs[17] = '{"gt_05_03",   OP_GT,   8'h05, 8'h03, 8'h01, 1'b0};
        vecs[18] = '{"gt_03_05",   OP_GT,   8'h03, 8'h05, 8'h00, 1'b0};
        vecs[19] = '{"gt_05_05",   OP_GT,   8'h05, 8'h05, 8'h00, 1'b0};
        vecs[20] = '{"eq_5a_5a",   OP_EQ,   8'h5A, 8'h5A, 8'h01, 1'b0};
        vecs[21] = '{"eq_5a_5b",   OP_EQ,   8'h5A, 8'h5B, 8'h00, 1'b0};

        // Reset held with random inputs and a running clock.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), 8'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
            check("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(OP_ADD, 8'h33, 8'hCC);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("release_first", 8'hFF, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            model(vecs[i].op, vecs[i].a, vecs[i].b, er, ec, ev);
            @(posedge clk);
            #1;
            check_val(vecs[i].name, vecs[i].res, vecs[i].c, ev);
            $display("vec %s op=%h a=%h b=%h -> result=%h carry=%b", vecs[i].name, vecs[i].op,
                     vecs[i].a, vecs[i].b, result, carry_out);
        end

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 :
                  ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            drive(rop, ra, rb);
            model(rop, ra, rb, er, ec, ev);
            @(posedge clk);
            #1;
            check_val("random", er, ec, ev);
            $display("rnd %0d op=%h a=%h b=%h -> result=%h carry=%b exp=%h/%b", i, rop, ra, rb,
                     result, carry_out, er, ec);
        end

        // Reset pulse in the middle of a stream.
        @(negedge clk);
        drive(OP_ADD, 8'h33, 8'hCC);
        @(posedge clk);
        #1;
        check_val("pre_reset", 8'hFF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("clear_held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_SUB, 8'h05, 8'h07);
        @(posedge clk);
        #1;
        check_val("resume_sub", 8'hFE, 1'b1, 1'b0);
        @(negedge clk);
        drive(OP_ADD, 8'h7F, 8'h01);
        model(OP_ADD, 8'h7F, 8'h01, er, ec, ev);
        @(posedge clk);
        #1;
        check_val("resume_add_ovf", er, ec, ev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
